// File: rtl/synth_pkg.sv
// Shared constants and width helpers for the synth I2S output stage.
package synth_pkg;

    // Word-select levels driven on LRCLK.
    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    // Width of the BCLK half-period divider; kept at least one bit wide so a
    // divide-by-one configuration still has a legal counter.
    function automatic int unsigned div_cnt_w(input int unsigned bclk_half);
        return (bclk_half > 1) ? $clog2(bclk_half) : 1;
    endfunction

    // Width of the frame bit index, which spans both channel slots.
    function automatic int unsigned bit_idx_w(input int unsigned slot_width);
        return (slot_width > 1) ? $clog2(2 * slot_width) : 1;
    endfunction

endpackage

// File: rtl/synth_bclk_gen.sv
// Bit-clock generator: divides ctl_clk down to BCLK and flags the cycle whose
// edge produces the BCLK falling transition.
module synth_bclk_gen
    import synth_pkg::*;
#(
    parameter int unsigned BCLK_HALF = 4
) (
    input  logic ctl_clk_i,
    input  logic ctl_rst_i,
    output logic bclk_o,
    output logic fall_o
);

    localparam int unsigned   DW     = div_cnt_w(BCLK_HALF);
    localparam logic [DW-1:0] DIV_TC = DW'(BCLK_HALF - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic          div_tc;

    assign div_tc = (div_cnt_q == DIV_TC);

    // Half-period counter wraps at terminal count and toggles BCLK there.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        bclk_d    = bclk_q;
        if (div_tc) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end
    end

    // Divider and BCLK registers.
    always_ff @(posedge ctl_clk_i or negedge ctl_rst_i) begin
        if (!ctl_rst_i) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    // High for one cycle: the next edge takes BCLK from 1 to 0.
    assign fall_o = div_tc & bclk_q;

endmodule

// File: rtl/synth_i2s_tx.sv
// I2S transmitter for the mono synth output. Captures a sample on each rising
// edge of aud_freq into a one-deep holding register and sends it on both
// channels of a standard (one-bit-delayed, MSB-first) I2S frame.
module synth_i2s_tx
    import synth_pkg::*;
#(
    parameter int unsigned BITWIDTH   = 24,
    parameter int unsigned SLOT_WIDTH = 32,
    parameter int unsigned BCLK_HALF  = 4
) (
    input  logic                ctl_clk,
    input  logic                ctl_rst,
    input  logic                aud_freq,
    input  logic [BITWIDTH-1:0] wave_in,
    input  logic                clr_flags,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                underrun,
    output logic                overrun
);

    localparam int unsigned   BW      = bit_idx_w(SLOT_WIDTH);
    localparam logic [BW-1:0] B_LAST  = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0] B_SLOT  = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0] POS_LSB = BW'(BITWIDTH);
    // With no padding bits the delayed LSB of one slot lands on bit 0 of the next.
    localparam bit            NO_PAD  = (SLOT_WIDTH == BITWIDTH);

    logic                aud_prev_q;
    logic [BITWIDTH-1:0] hold_q, hold_d;
    logic                pending_q, pending_d;
    logic                armed_q, armed_d;
    logic [BITWIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]       b_q, b_d;
    logic                lrclk_q, lrclk_d;
    logic                sdata_q, sdata_d;
    logic                underrun_q, underrun_d;
    logic                overrun_q, overrun_d;

    logic                bclk;
    logic                bclk_fall;
    logic                capture;
    logic                load;
    logic                under_set;
    logic                over_set;
    logic [BW-1:0]       pos;
    logic [BITWIDTH-1:0] shifted;

    synth_bclk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_bclk_gen (
        .ctl_clk_i (ctl_clk),
        .ctl_rst_i (ctl_rst),
        .bclk_o    (bclk),
        .fall_o    (bclk_fall)
    );

    assign capture = aud_freq & ~aud_prev_q;
    // Frame load happens on the fall that wraps the bit index back to 0.
    assign load    = bclk_fall & (b_q == B_LAST);

    // Sample capture, pending/armed bookkeeping and frame load selection.
    always_comb begin
        hold_d    = hold_q;
        pending_d = pending_q;
        armed_d   = armed_q;
        shift_d   = shift_q;
        under_set = 1'b0;
        over_set  = 1'b0;
        if (capture) begin
            hold_d  = wave_in;
            armed_d = 1'b1;
        end
        if (load) begin
            pending_d = 1'b0;
            if (capture) begin
                // Fresh sample arriving on the load cycle goes straight out.
                shift_d  = wave_in;
                over_set = pending_q;
            end else begin
                // hold_q still holds the last sample, so an underrun repeats it.
                shift_d   = hold_q;
                under_set = armed_q & ~pending_q;
            end
        end else if (capture) begin
            pending_d = 1'b1;
            over_set  = pending_q;
        end
    end

    // Bit index, word select and serial data all advance on the BCLK fall.
    always_comb begin
        b_d     = b_q;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        pos     = '0;
        shifted = '0;
        if (bclk_fall) begin
            b_d     = (b_q == B_LAST) ? '0 : b_q + 1'b1;
            lrclk_d = (b_d >= B_SLOT) ? I2S_RIGHT : I2S_LEFT;
            pos     = (b_d >= B_SLOT) ? (b_d - B_SLOT) : b_d;
            shifted = shift_q << (pos - 1'b1);
            if (pos == '0) begin
                // At b=0 shift_q is still the previous frame's sample.
                sdata_d = NO_PAD ? shift_q[0] : 1'b0;
            end else if (pos <= POS_LSB) begin
                sdata_d = shifted[BITWIDTH-1];
            end else begin
                sdata_d = 1'b0;
            end
        end
    end

    // Sticky status flags; clear wins over a same-cycle set.
    always_comb begin
        underrun_d = underrun_q | under_set;
        overrun_d  = overrun_q | over_set;
        if (clr_flags) begin
            underrun_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            aud_prev_q <= 1'b0;
            hold_q     <= '0;
            pending_q  <= 1'b0;
            armed_q    <= 1'b0;
            shift_q    <= '0;
            b_q        <= '0;
            lrclk_q    <= I2S_LEFT;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            aud_prev_q <= aud_freq;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            armed_q    <= armed_d;
            shift_q    <= shift_d;
            b_q        <= b_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign i2s_bclk  = bclk;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_synth_i2s_tx.sv
// Bench for synth_i2s_tx at BCLK_HALF=2, SLOT_WIDTH=32, BITWIDTH=24.
// A receiver model decodes every frame on BCLK rises; expected frame contents
// are queued as stimulus is applied and compared as each frame completes.
module tb_synth_i2s_tx;

    localparam int BITW  = 24;
    localparam int SLOT  = 32;
    localparam int HALF  = 2;
    localparam int NBITS = 2 * SLOT;

    logic            ctl_clk = 1'b0;
    logic            ctl_rst;
    logic            aud_freq;
    logic [BITW-1:0] wave_in;
    logic            clr_flags;
    logic            i2s_bclk;
    logic            i2s_lrclk;
    logic            i2s_sdata;
    logic            underrun;
    logic            overrun;

    synth_i2s_tx #(
        .BITWIDTH   (BITW),
        .SLOT_WIDTH (SLOT),
        .BCLK_HALF  (HALF)
    ) dut (
        .ctl_clk   (ctl_clk),
        .ctl_rst   (ctl_rst),
        .aud_freq  (aud_freq),
        .wave_in   (wave_in),
        .clr_flags (clr_flags),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata),
        .underrun  (underrun),
        .overrun   (overrun)
    );

    always #5 ctl_clk = ~ctl_clk;

    typedef struct {
        logic [BITW-1:0] l;
        logic [BITW-1:0] r;
        bit              pad_ok;
        bit              lr_ok;
        bit              per_ok;
    } frame_t;

    typedef struct {
        logic [BITW-1:0] wave;
        logic            exp_under;
        logic            exp_over;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Receiver model state (written only by the monitor process).
    frame_t          got [64];
    int              got_cnt    = 0;
    int              fstart_cnt = 0;
    int              m_rb;
    int              m_cyc;
    int              m_last;
    logic            m_prev;
    logic [BITW-1:0] m_l;
    logic [BITW-1:0] m_r;
    bit              m_pad_ok;
    bit              m_lr_ok;
    bit              m_per_ok;

    // Scoreboard (touched only by the stimulus process).
    logic [BITW-1:0] exp_q [$];
    int              rd_idx = 0;

    initial begin
        m_rb = 0; m_cyc = 0; m_last = -1; m_prev = 1'b0;
        m_l = '0; m_r = '0; m_pad_ok = 1; m_lr_ok = 1; m_per_ok = 1;
        forever begin
            @(negedge ctl_clk);
            m_cyc++;
            if (!ctl_rst) begin
                m_rb   = 0;
                m_prev = 1'b0;
                m_last = -1;
            end else begin
                if (i2s_bclk && !m_prev) begin
                    if (m_rb == 0) begin
                        m_l = '0; m_r = '0;
                        m_pad_ok = 1; m_lr_ok = 1; m_per_ok = 1;
                        fstart_cnt++;
                    end
                    if (m_last >= 0 && (m_cyc - m_last) != 2 * HALF) m_per_ok = 0;
                    m_last = m_cyc;
                    if (i2s_lrclk !== (m_rb >= SLOT)) m_lr_ok = 0;
                    if (m_rb >= 1 && m_rb <= BITW)
                        m_l = {m_l[BITW-2:0], i2s_sdata};
                    else if (m_rb >= SLOT + 1 && m_rb <= SLOT + BITW)
                        m_r = {m_r[BITW-2:0], i2s_sdata};
                    else if (i2s_sdata !== 1'b0)
                        m_pad_ok = 0;
                    if (m_rb == NBITS - 1 && got_cnt < 64) begin
                        got[got_cnt] = '{m_l, m_r, m_pad_ok, m_lr_ok, m_per_ok};
                        got_cnt++;
                    end
                    m_rb = (m_rb + 1) % NBITS;
                end
                m_prev = i2s_bclk;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_fstart();
        int start;
        int n;
        start = fstart_cnt;
        n = 0;
        while (fstart_cnt == start && n < 600) begin
            @(posedge ctl_clk);
            #1;
            n++;
        end
        total++;
        if (fstart_cnt == start) begin
            bad++;
            $display("FAIL frame_start_timeout: got no frame start, expected one within 600 cycles");
        end
    endtask

    task automatic drain();
        logic [BITW-1:0] e;
        while (rd_idx < got_cnt) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got frame %0d, expected a queued expectation", rd_idx);
            end else begin
                e = exp_q.pop_front();
                chk("frame_left",  32'(got[rd_idx].l), 32'(e));
                chk("frame_right", 32'(got[rd_idx].r), 32'(e));
                chk("frame_pad",   32'(got[rd_idx].pad_ok), 32'd1);
                chk("frame_lrclk", 32'(got[rd_idx].lr_ok),  32'd1);
                chk("bclk_period", 32'(got[rd_idx].per_ok), 32'd1);
            end
            rd_idx++;
        end
    endtask

    task automatic next_frame(input logic [BITW-1:0] e);
        wait_fstart();
        drain();
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic [BITW-1:0] w);
        wave_in  = w;
        aud_freq = 1'b1;
        @(posedge ctl_clk);
        #1;
        aud_freq = 1'b0;
        wave_in  = ~w;
    endtask

    task automatic clr_pulse();
        clr_flags = 1'b1;
        @(posedge ctl_clk);
        #1;
        clr_flags = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{24'h800001, 1'b0, 1'b0};
        vecs[1] = '{24'h7FFFFF, 1'b0, 1'b0};
        vecs[2] = '{24'hFFFFFF, 1'b0, 1'b0};
        vecs[3] = '{24'h000001, 1'b0, 1'b0};
        vecs[4] = '{24'hA5C33C, 1'b0, 1'b0};

        ctl_rst   = 1'b0;
        aud_freq  = 1'b0;
        wave_in   = '0;
        clr_flags = 1'b0;
        repeat (10) @(posedge ctl_clk);
        #1;
        chk("rst_bclk",     32'(i2s_bclk),  32'd0);
        chk("rst_lrclk",    32'(i2s_lrclk), 32'd0);
        chk("rst_sdata",    32'(i2s_sdata), 32'd0);
        chk("rst_underrun", 32'(underrun),  32'd0);
        chk("rst_overrun",  32'(overrun),   32'd0);
        @(negedge ctl_clk);
        ctl_rst = 1'b1;

        // Idle after reset: silent frames, no flags.
        for (int f = 0; f < 3; f++) next_frame('0);
        next_frame('0);
        chk("idle_underrun", 32'(underrun), 32'd0);
        chk("idle_overrun",  32'(overrun),  32'd0);

        // One capture per frame; each appears in the following frame.
        for (int i = 0; i < 5; i++) begin
            pulse(vecs[i].wave);
            next_frame(vecs[i].wave);
            chk("vec_underrun", 32'(underrun), 32'(vecs[i].exp_under));
            chk("vec_overrun",  32'(overrun),  32'(vecs[i].exp_over));
        end

        // Strobe held high: one capture only, then repeats with underrun.
        wave_in  = 24'h123456;
        aud_freq = 1'b1;
        repeat (5) @(posedge ctl_clk);
        #1;
        wave_in = 24'h654321;
        next_frame(24'h123456);
        chk("held_underrun_1", 32'(underrun), 32'd0);
        next_frame(24'h123456);
        chk("held_underrun_2", 32'(underrun), 32'd1);
        chk("held_overrun",    32'(overrun),  32'd0);
        aud_freq = 1'b0;

        // Two captures in one frame: overrun, newest sample wins.
        clr_pulse();
        chk("clr_underrun", 32'(underrun), 32'd0);
        pulse(24'hAAAAAA);
        repeat (9) @(posedge ctl_clk);
        #1;
        pulse(24'h555555);
        chk("ovr_set", 32'(overrun), 32'd1);
        next_frame(24'h555555);
        chk("ovr_sticky",     32'(overrun),  32'd1);
        chk("ovr_no_underrun", 32'(underrun), 32'd0);
        clr_pulse();
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Next frame repeats with underrun; then a capture on the load cycle.
        next_frame(24'h555555);
        chk("rep_underrun", 32'(underrun), 32'd1);
        clr_pulse();
        repeat (251) @(posedge ctl_clk);
        #1;
        wave_in  = 24'h00FFFF;
        aud_freq = 1'b1;
        @(posedge ctl_clk);
        #1;
        aud_freq = 1'b0;
        wave_in  = '0;
        next_frame(24'h00FFFF);
        chk("byp_underrun", 32'(underrun), 32'd0);
        chk("byp_overrun",  32'(overrun),  32'd0);
        next_frame(24'h00FFFF);
        chk("byp_not_pending", 32'(underrun), 32'd1);

        // Asynchronous reset at b=40 while BCLK is high.
        repeat (160) @(posedge ctl_clk);
        #1;
        chk("pre_rst_bclk",  32'(i2s_bclk),  32'd1);
        chk("pre_rst_lrclk", 32'(i2s_lrclk), 32'd1);
        ctl_rst = 1'b0;
        #1;
        chk("arst_bclk",     32'(i2s_bclk),  32'd0);
        chk("arst_lrclk",    32'(i2s_lrclk), 32'd0);
        chk("arst_sdata",    32'(i2s_sdata), 32'd0);
        chk("arst_underrun", 32'(underrun),  32'd0);
        chk("arst_overrun",  32'(overrun),   32'd0);
        exp_q.delete();
        repeat (5) @(posedge ctl_clk);
        @(negedge ctl_clk);
        ctl_rst = 1'b1;

        next_frame('0);
        next_frame('0);
        chk("post_rst_underrun", 32'(underrun), 32'd0);
        wait_fstart();
        drain();
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
